// File: rtl/tx_gain_pkg.sv
// Shared types and constants for the TX gain/ramp stage.
package tx_gain_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam int unsigned GW        = 16;
    localparam int unsigned CW        = 16;
    localparam int unsigned GFRAC     = 14;
    localparam logic [GW-1:0] GAIN_ONE = 16'h4000;

    localparam int unsigned ADDR_GAIN = 0;
    localparam int unsigned ADDR_CTRL = 1;

    localparam logic [5:0] CTRL_RESET = 6'h04;

endpackage

// File: rtl/tx_gain_chan.sv
// One channel: registered signed multiply, then round-half-up and saturate to OWIDTH.
module tx_gain_chan
    import tx_gain_pkg::*;
#(
    parameter int unsigned IWIDTH = 24,
    parameter int unsigned OWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en1,
    input  logic                     en2,
    input  logic signed [IWIDTH-1:0] sample,
    input  logic signed [GW-1:0]     gain,
    output logic signed [OWIDTH-1:0] result
);

    localparam int unsigned PW = IWIDTH + GW;
    localparam int          SH = GFRAC + IWIDTH - OWIDTH;
    localparam int unsigned SW = OWIDTH + 3;
    localparam logic signed [PW:0] RND =
        (SH > 0) ? ((PW+1)'(1) <<< ((SH > 0) ? SH - 1 : 0)) : '0;
    localparam logic [OWIDTH-1:0] MAXV = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic [OWIDTH-1:0] MINV = {1'b1, {(OWIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW:0]   sum_c;
    logic signed [SW-1:0] shr_c;
    logic                 ovf_c;

    assign sum_c = {prod[PW-1], prod} + RND;
    assign shr_c = SW'(sum_c >>> SH);
    // The top bits above the output sign bit must all match the sign, else clip.
    assign ovf_c = shr_c[SW-1:OWIDTH-1] != {(SW-OWIDTH+1){shr_c[SW-1]}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod   <= '0;
            result <= '0;
        end else begin
            if (en1) begin
                prod <= PW'(sample) * PW'(gain);
            end
            if (en2) begin
                result <= ovf_c ? (shr_c[SW-1] ? MINV : MAXV) : shr_c[OWIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/tx_gain_ramp.sv
// TX gain stage with per-channel gain, linear start/stop/change ramps, round and saturate.
module tx_gain_ramp
    import tx_gain_pkg::*;
#(
    parameter int unsigned IWIDTH = 24,
    parameter int unsigned OWIDTH = 16,
    parameter int unsigned BASE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    input  logic                     run,
    input  logic                     in_stb,
    input  logic signed [IWIDTH-1:0] in_i,
    input  logic signed [IWIDTH-1:0] in_q,
    output logic                     out_stb,
    output logic signed [OWIDTH-1:0] out_i,
    output logic signed [OWIDTH-1:0] out_q,
    output logic                     active,
    output logic [7:0]               debug
);

    logic [GW-1:0]        gain_i_r, gain_q_r;
    logic                 swap_r, bypass_r;
    logic [3:0]           shift_r;

    state_t               state;
    logic signed [GW-1:0] cur_i, cur_q, tgt_i, tgt_q;
    logic signed [GW:0]   step_i, step_q;
    logic [CW-1:0]        cnt;
    logic                 swap_act, run_q, stb_d1;

    logic                 gain_wr_c, ctrl_wr_c, ramping_c;
    logic                 start_up_c, start_dn_c, instant_c;
    logic signed [GW-1:0] rtgt_i_c, rtgt_q_c;
    logic signed [GW:0]   diff_i_c, diff_q_c, inc_i_c, inc_q_c;
    logic signed [IWIDTH-1:0] smp_i_c, smp_q_c;

    assign gain_wr_c = set_stb && (set_addr == 8'(BASE + ADDR_GAIN));
    assign ctrl_wr_c = set_stb && (set_addr == 8'(BASE + ADDR_CTRL));
    assign ramping_c = (state == RAMP_UP) || (state == RAMP_DOWN);

    // Run fall beats a simultaneous gain write; a gain write only retargets while heading up.
    assign start_dn_c = !run && ((state == RAMP_UP) || (state == RUN));
    assign start_up_c = run && ((state == IDLE) || (state == RAMP_DOWN) ||
                                (gain_wr_c && ((state == RAMP_UP) || (state == RUN))));
    assign instant_c  = (shift_r == 4'd0) || bypass_r;

    assign rtgt_i_c = start_dn_c ? '0 : (gain_wr_c ? set_data[31:16] : gain_i_r);
    assign rtgt_q_c = start_dn_c ? '0 : (gain_wr_c ? set_data[15:0]  : gain_q_r);
    assign diff_i_c = {rtgt_i_c[GW-1], rtgt_i_c} - {cur_i[GW-1], cur_i};
    assign diff_q_c = {rtgt_q_c[GW-1], rtgt_q_c} - {cur_q[GW-1], cur_q};
    assign inc_i_c  = {cur_i[GW-1], cur_i} + step_i;
    assign inc_q_c  = {cur_q[GW-1], cur_q} + step_q;

    assign smp_i_c = swap_act ? in_q : in_i;
    assign smp_q_c = swap_act ? in_i : in_q;

    assign active = (state != IDLE);
    assign debug  = {3'b000, swap_act, state, ramping_c, run_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gain_i_r <= GAIN_ONE;
            gain_q_r <= GAIN_ONE;
            swap_r   <= CTRL_RESET[5];
            bypass_r <= CTRL_RESET[4];
            shift_r  <= CTRL_RESET[3:0];
            state    <= IDLE;
            cur_i    <= '0;
            cur_q    <= '0;
            tgt_i    <= '0;
            tgt_q    <= '0;
            step_i   <= '0;
            step_q   <= '0;
            cnt      <= '0;
            swap_act <= 1'b0;
            run_q    <= 1'b0;
            stb_d1   <= 1'b0;
            out_stb  <= 1'b0;
        end else begin
            run_q   <= run;
            stb_d1  <= in_stb;
            out_stb <= stb_d1;

            if (gain_wr_c) begin
                gain_i_r <= set_data[31:16];
                gain_q_r <= set_data[15:0];
            end
            if (ctrl_wr_c) begin
                swap_r   <= set_data[5];
                bypass_r <= set_data[4];
                shift_r  <= set_data[3:0];
            end

            if (start_up_c || start_dn_c) begin
                swap_act <= swap_r;
                tgt_i    <= rtgt_i_c;
                tgt_q    <= rtgt_q_c;
                if (instant_c) begin
                    cnt    <= '0;
                    step_i <= '0;
                    step_q <= '0;
                    if (start_dn_c) begin
                        state <= IDLE;
                        cur_i <= '0;
                        cur_q <= '0;
                    end else begin
                        state <= RUN;
                        cur_i <= bypass_r ? GAIN_ONE : rtgt_i_c;
                        cur_q <= bypass_r ? GAIN_ONE : rtgt_q_c;
                    end
                end else begin
                    state  <= start_dn_c ? RAMP_DOWN : RAMP_UP;
                    cnt    <= CW'(1) << shift_r;
                    step_i <= diff_i_c >>> shift_r;
                    step_q <= diff_q_c >>> shift_r;
                end
            end else if (in_stb && ramping_c) begin
                // Last strobe lands exactly on target so truncated steps never leave residue.
                if (cnt == CW'(1)) begin
                    cnt   <= '0;
                    cur_i <= tgt_i;
                    cur_q <= tgt_q;
                    state <= (state == RAMP_UP) ? RUN : IDLE;
                end else begin
                    cnt   <= cnt - CW'(1);
                    cur_i <= inc_i_c[GW-1:0];
                    cur_q <= inc_q_c[GW-1:0];
                end
            end
        end
    end

    tx_gain_chan #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH)) u_chan_i (
        .clk    (clk),
        .rst    (rst),
        .en1    (in_stb),
        .en2    (stb_d1),
        .sample (smp_i_c),
        .gain   (cur_i),
        .result (out_i)
    );

    tx_gain_chan #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH)) u_chan_q (
        .clk    (clk),
        .rst    (rst),
        .en1    (in_stb),
        .en2    (stb_d1),
        .sample (smp_q_c),
        .gain   (cur_q),
        .result (out_q)
    );

endmodule

// File: tb/tb_tx_gain_ramp.sv
// Bench for tx_gain_ramp: directed ramp/reset sequences, a vector table, and a random run vs. a reference model.
module tb_tx_gain_ramp;

    localparam int unsigned IW     = 16;
    localparam int unsigned OW     = 16;
    localparam int unsigned BASE_A = 16;

    logic                 clk;
    logic                 rst;
    logic                 set_stb;
    logic [7:0]           set_addr;
    logic [31:0]          set_data;
    logic                 run;
    logic                 in_stb;
    logic signed [IW-1:0] in_i, in_q;
    logic                 out_stb;
    logic signed [OW-1:0] out_i, out_q;
    logic                 active;
    logic [7:0]           debug;

    int checks = 0;
    int errors = 0;
    int got_i[$], got_q[$], expq[$];

    typedef struct {
        logic [15:0] gain;
        int a;
        int b;
        int ea;
        int eb;
    } vec_t;
    vec_t vecs[6];

    tx_gain_ramp #(.IWIDTH(IW), .OWIDTH(OW), .BASE(BASE_A)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .run      (run),
        .in_stb   (in_stb),
        .in_i     (in_i),
        .in_q     (in_q),
        .out_stb  (out_stb),
        .out_i    (out_i),
        .out_q    (out_q),
        .active   (active),
        .debug    (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = 8'(addr);
        set_data = data;
        cyc();
        set_stb  = 1'b0;
    endtask

    // Strobe n samples back to back, then drain the pipe, collecting every output beat.
    task automatic run_strobes(input int n, input int a, input int b);
        got_i.delete();
        got_q.delete();
        in_i = IW'(a);
        in_q = IW'(b);
        for (int k = 0; k < n + 2; k++) begin
            in_stb = (k < n);
            cyc();
            if (out_stb) begin
                got_i.push_back(int'(out_i));
                got_q.push_back(int'(out_q));
            end
        end
        in_stb = 1'b0;
    endtask

    task automatic cmp_seq(input string name);
        chk({name, "_len"}, got_i.size(), expq.size());
        for (int k = 0; k < expq.size(); k++) begin
            if (k < got_i.size()) chk(name, got_i[k], expq[k]);
        end
    endtask

    function automatic int st();
        return int'(debug[3:2]);
    endfunction

    // Reference arithmetic: round half up of in*g/2^14, clipped to 16-bit signed.
    function automatic int scale(input int x, input int g);
        longint p;
        p = longint'(x) * longint'(g) + 64'sd8192;
        p = p >>> 14;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    function automatic int sx16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference model state: "on" flag plus direction and strobes remaining.
    int m_gi, m_gq, m_sh_r;
    bit m_swap_r, m_byp_r, m_swap, m_active, m_up, m_prev_run;
    int m_left, m_cur_i, m_cur_q, m_tgt_i, m_tgt_q, m_step_i, m_step_q;
    bit p1_stb, e_stb;
    int p1_i, p1_q, e_i, e_q;

    task automatic model_reset();
        m_gi = 16384; m_gq = 16384; m_sh_r = 4;
        m_swap_r = 0; m_byp_r = 0; m_swap = 0;
        m_active = 0; m_up = 0; m_prev_run = 0;
        m_left = 0; m_cur_i = 0; m_cur_q = 0; m_tgt_i = 0; m_tgt_q = 0;
        m_step_i = 0; m_step_q = 0;
        p1_stb = 0; e_stb = 0; p1_i = 0; p1_q = 0; e_i = 0; e_q = 0;
    endtask

    task automatic model_step();
        bit gwr, cwr, up_req, dn_req;
        int ti, tq, ai, aq;
        e_stb = p1_stb;
        if (p1_stb) begin
            e_i = p1_i;
            e_q = p1_q;
        end
        p1_stb = in_stb;
        if (in_stb) begin
            ai = m_swap ? int'(in_q) : int'(in_i);
            aq = m_swap ? int'(in_i) : int'(in_q);
            p1_i = scale(ai, m_cur_i);
            p1_q = scale(aq, m_cur_q);
        end
        gwr = set_stb && (int'(set_addr) == int'(BASE_A));
        cwr = set_stb && (int'(set_addr) == int'(BASE_A) + 1);
        ti  = gwr ? sx16(set_data[31:16]) : m_gi;
        tq  = gwr ? sx16(set_data[15:0])  : m_gq;
        up_req = run && (!m_active || !m_up || gwr);
        dn_req = !run && m_active && m_up;
        if (up_req || dn_req) begin
            m_swap = m_swap_r;
            if (dn_req) begin
                ti = 0;
                tq = 0;
            end
            m_tgt_i = ti;
            m_tgt_q = tq;
            if (m_sh_r == 0 || m_byp_r) begin
                m_left = 0;
                if (dn_req) begin
                    m_active = 0;
                    m_up = 0;
                    m_cur_i = 0;
                    m_cur_q = 0;
                end else begin
                    m_active = 1;
                    m_up = 1;
                    m_cur_i = m_byp_r ? 16384 : ti;
                    m_cur_q = m_byp_r ? 16384 : tq;
                end
            end else begin
                m_active = 1;
                m_up = up_req;
                m_left = 1 << m_sh_r;
                m_step_i = (ti - m_cur_i) >>> m_sh_r;
                m_step_q = (tq - m_cur_q) >>> m_sh_r;
            end
        end else if (in_stb && m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_cur_i = m_tgt_i;
                m_cur_q = m_tgt_q;
                if (!m_up) m_active = 0;
            end else begin
                m_cur_i += m_step_i;
                m_cur_q += m_step_q;
            end
        end
        if (gwr) begin
            m_gi = sx16(set_data[31:16]);
            m_gq = sx16(set_data[15:0]);
        end
        if (cwr) begin
            m_swap_r = set_data[5];
            m_byp_r  = set_data[4];
            m_sh_r   = int'(set_data[3:0]);
        end
        m_prev_run = run;
    endtask

    function automatic int exp_debug();
        int s;
        if (!m_active)    s = 0;
        else if (!m_up)   s = 3;
        else if (m_left > 0) s = 1;
        else              s = 2;
        return (int'(m_swap) << 4) | (s << 2) |
               (int'(m_active && m_left > 0) << 1) | int'(m_prev_run);
    endfunction

    initial begin
        vecs[0] = '{16'h4000,   1000,  -1000,  1000,  -1000};
        vecs[1] = '{16'h7FFF,  32767, -32768, 32767, -32768};
        vecs[2] = '{16'h2000,      3,     -3,     2,     -1};
        vecs[3] = '{16'h2000,      1,     -1,     1,      0};
        vecs[4] = '{16'hC000,    100, -32768,  -100,  32767};
        vecs[5] = '{16'h0000,   1234,     -5,     0,      0};

        rst = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        run = 1'b0; in_stb = 1'b0; in_i = '0; in_q = '0;
        cyc(); cyc();
        chk("reset_out_stb", int'(out_stb), 0);
        chk("reset_out_i", int'(out_i), 0);
        chk("reset_active", int'(active), 0);
        chk("reset_debug", int'(debug), 0);
        rst = 1'b1;
        cyc();

        // Ramp-up over four strobes
        wr(BASE_A + 1, 32'h2);
        run = 1'b1;
        cyc();
        chk("up_state_start", st(), 1);
        run_strobes(3, 8192, 0);
        expq = {0, 2048, 4096};
        cmp_seq("ramp_up_a");
        chk("up_state_mid", st(), 1);
        run_strobes(3, 8192, 0);
        expq = {6144, 8192, 8192};
        cmp_seq("ramp_up_b");
        chk("up_state_run", st(), 2);

        // Ramp-down to idle
        run = 1'b0;
        cyc();
        chk("dn_state", st(), 3);
        run_strobes(4, 8192, 0);
        expq = {8192, 6144, 4096, 2048};
        cmp_seq("ramp_down");
        chk("dn_active", int'(active), 0);
        chk("dn_state_idle", st(), 0);

        // Recovery from partial ramp-down
        run = 1'b1;
        cyc();
        run_strobes(5, 8192, 0);
        run = 1'b0;
        cyc();
        run_strobes(2, 8192, 0);
        expq = {8192, 6144};
        cmp_seq("rec_down");
        run = 1'b1;
        cyc();
        chk("rec_state", st(), 1);
        run_strobes(5, 8192, 0);
        expq = {4096, 5120, 6144, 7168, 8192};
        cmp_seq("rec_up");

        // Reset mid ramp-down with strobes flowing
        run = 1'b0;
        cyc();
        in_stb = 1'b1; in_i = 16'sd8192;
        cyc(); cyc();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_out_stb", int'(out_stb), 0);
        chk("rst_mid_out_i", int'(out_i), 0);
        chk("rst_mid_active", int'(active), 0);
        chk("rst_mid_state", st(), 0);
        cyc(); cyc();
        chk("rst_hold_out_stb", int'(out_stb), 0);
        rst = 1'b1;
        cyc(); cyc(); cyc();
        chk("rst_after_active", int'(active), 0);
        chk("rst_after_out_i", int'(out_i), 0);
        in_stb = 1'b0;
        cyc();

        // Unity gain, no ramp: exact two-cycle latency
        wr(BASE_A + 1, 32'h0);
        run = 1'b1;
        cyc();
        chk("unity_state", st(), 2);
        in_i = 16'sd1000; in_stb = 1'b1;
        cyc();
        in_stb = 1'b0;
        chk("unity_lat1", int'(out_stb), 0);
        cyc();
        chk("unity_lat2", int'(out_stb), 1);
        chk("unity_out", int'(out_i), 1000);
        cyc();

        for (int v = 0; v < 6; v++) begin
            wr(BASE_A, {vecs[v].gain, vecs[v].gain});
            run_strobes(1, vecs[v].a, vecs[v].b);
            chk($sformatf("vec%0d_len", v), got_i.size(), 1);
            if (got_i.size() == 1) begin
                chk($sformatf("vec%0d_i", v), got_i[0], vecs[v].ea);
                chk($sformatf("vec%0d_q", v), got_q[0], vecs[v].eb);
            end
        end

        // Swap takes effect at the ramp start caused by the gain write
        wr(BASE_A + 1, 32'h20);
        wr(BASE_A, 32'h4000_4000);
        chk("swap_debug", int'(debug[4]), 1);
        run_strobes(1, 5, 7);
        expq = {7};
        cmp_seq("swap_i");
        if (got_q.size() == 1) chk("swap_q", got_q[0], 5);

        // Randomized run against the reference model
        run = 1'b0; rst = 1'b0;
        cyc(); cyc();
        model_reset();
        rst = 1'b1;
        cyc();
        for (int c = 0; c < 3000; c++) begin
            in_stb = ($urandom_range(0, 3) != 0);
            in_i   = IW'($urandom);
            in_q   = IW'($urandom);
            if ($urandom_range(0, 15) == 0) run = ~run;
            set_stb = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       set_addr = 8'(BASE_A);
                1:       set_addr = 8'(BASE_A + 1);
                default: set_addr = 8'h05;
            endcase
            set_data = $urandom;
            if (set_addr == 8'(BASE_A + 1)) begin
                set_data[3:2] = 2'b00;
                set_data[4]   = ($urandom_range(0, 7) == 0);
            end
            model_step();
            cyc();
            chk("rnd_out_stb", int'(out_stb), int'(e_stb));
            chk("rnd_out_i", int'(out_i), e_i);
            chk("rnd_out_q", int'(out_q), e_q);
            chk("rnd_active", int'(active), int'(m_active));
            chk("rnd_debug", int'(debug), exp_debug());
        end
        set_stb = 1'b0;
        in_stb  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_gain_ramp.md
# tx_gain_ramp

Parametrised transmit gain stage for the TX DSP chain. It sits between the interpolator/CORDIC output and the DAC interface. It supersedes the fixed 18x18 scale multiply with per-channel gain, configurable widths, and click-free linear gain ramps on start, stop and gain change. Rounding and saturation to the DAC width are built in.

## Interface
- IWIDTH, 24: input sample width, signed.
- OWIDTH, 16: output sample width, signed; must be ≤ IWIDTH+14.
- BASE, 0: settings-bus base address.
- clk  in  1  sole clock (DAC-rate domain).
- rst  in  1  asynchronous, active-low reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- run  in  1  stream enable; rise starts the ramp-up, fall starts the ramp-down.
- in_stb  in  1  input sample valid (one sample per strobe).
- in_i, in_q  in  IWIDTH  input I/Q samples, signed.
- out_stb  out  1  output valid, equal to in_stb delayed 2 cycles.
- out_i, out_q  out  OWIDTH  scaled, rounded, saturated samples.
- active  out  1  high in any state other than IDLE.
- debug  out  8  {3'b0, swap, state[1:0], ramping, run}.

## Operation
- Settings registers:
  - BASE+0 = {gain_i[31:16], gain_q[15:0]}. Signed Q2.14; 0x4000 = 1.0. Reset value 0x4000/0x4000.
  - BASE+1 = {swap_iq[5], bypass[4], ramp_shift[3:0]}. Reset value 0x04.
- Live gains: cur_i and cur_q, 16 bits each.
  - Ramp length is N = 2^ramp_shift input strobes.
  - At ramp start: step = (target − cur) >>> ramp_shift (arithmetic shift), and the counter is loaded with N.
  - Each in_stb: the sample uses the pre-update cur; then cur += step and the counter decrements.
  - On the last strobe, cur is set to exactly target.
- States:
  - IDLE: cur = 0; out_i = out_q = 0.
  - IDLE → RAMP_UP on run = 1, with target = gain regs. If ramp_shift = 0, go directly to RUN with cur = target.
  - RAMP_UP → RUN when the counter expires.
  - RUN: a write to BASE+0 re-enters RAMP_UP, ramping from the current cur to the new gain.
  - RAMP_UP or RUN → RAMP_DOWN on run = 0, with target = 0.
  - RAMP_DOWN → IDLE when the counter expires. Output samples still flow during RAMP_DOWN.
  - RAMP_DOWN → RAMP_UP if run = 1 again, ramping from the current cur (no jump to 0).
  - A BASE+0 write during RAMP_UP restarts the ramp from the current cur. The same write during RAMP_DOWN only updates the register.
  - A write to BASE+1 takes effect at the next ramp start.
- Simultaneous events:
  - run fall plus a gain write in the same cycle: RAMP_DOWN wins.
  - No in_stb: cur and the counter hold.
- Arithmetic, per channel:
  - prod = in × cur, IWIDTH+16 bits, signed.
  - out = (prod + 2^(S−1)) >>> S, where S = 14 + IWIDTH − OWIDTH. This is round half up.
  - Saturate to [−2^(OWIDTH−1), 2^(OWIDTH−1)−1].
- swap_iq exchanges the in_i and in_q inputs before multiplication.
- bypass forces cur = 0x4000 in all non-IDLE states; no ramping.

## Timing
- Reset (asynchronous, rst = 0) forces:
  - state = IDLE; cur = counter = 0.
  - out_stb = 0, out_i = out_q = 0, active = 0.
  - Settings registers to their reset values.
- Latency is 2 cycles from in_stb to out_stb:
  - Stage 1 registers the product.
  - Stage 2 registers the rounded and saturated result.
  - out_i/out_q hold their value between strobes.
- run is sampled every cycle. The state changes on the clock edge after run changes.
- Reset asserted mid-ramp aborts immediately. After deassert, nothing is output until run is seen high.
- Back-to-back in_stb on every cycle is supported.

## Structure
- Package tx_gain_pkg holds:
  - state enum {IDLE, RAMP_UP, RUN, RAMP_DOWN};
  - GAIN_ONE = 16'h4000, GFRAC = 14;
  - register offsets ADDR_GAIN = 0, ADDR_CTRL = 1.
- Sub-module tx_gain_chan, parameterised by IWIDTH/OWIDTH, implements the per-channel multiply → round → saturate pipeline. It is instantiated twice, for I and Q.
- The top level holds the settings registers, the FSM, and the ramp counter/step logic.

## Test plan
All scenarios use IWIDTH = OWIDTH = 16.
- Reset: drive rst = 0 mid-ramp with strobes → out_stb = 0, outputs = 0, active = 0, debug state = IDLE.
- Unity, no ramp: ramp_shift = 0, run = 1, in_i = 1000 → first out_i = 1000, two cycles after in_stb.
- Ramp-up: ramp_shift = 2, gain 0x4000, in_i = 8192 constant → out_i = 0, 2048, 4096, 6144, 8192, 8192…; state reaches RUN after the 4th strobe.
- Ramp-down and recovery:
  - Drop run in RUN with ramp_shift = 2, in_i = 8192 → out_i = 8192, 6144, 4096, 2048; then IDLE, active = 0.
  - Re-raise run after 2 down-steps → the ramp resumes upward from 0x2000 (value 4096).
- Saturation: gain 0x7FFF; in = 32767 → 32767; in = −32768 → −32768.
- Rounding and swap:
  - Rounding: gain 0x2000; in = 3 → 2; in = −3 → −1.
  - Swap: with swap_iq = 1, in_i = 5, in_q = 7 at unity → out_i = 7, out_q = 5.
